// File: rtl/apb_counter_bank.sv
// apb_counter_bank: APB3 slave holding NUM_CH up/down counters with per-channel
// CTRL / VALUE / COMPARE / STATUS registers at channel base ch*0x10.
// Define APB_CNT_IRQ_EN to build the compare/match/status logic and the IRQ
// output; without it COMPARE and STATUS read 0, IE reads 0 and IRQ is tied 0.
module apb_counter_bank #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic [31:0]       PADDR,
   input  logic              PSELx,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic [NUM_CH-1:0] CNT_EVT,
   output logic              IRQ
);

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_VALUE   = 2'd1,
      REG_COMPARE = 2'd2,
      REG_STATUS  = 2'd3
   } reg_e;

   // CTRL bit positions
   localparam int unsigned C_EN  = 0;
   localparam int unsigned C_DIR = 1;
   localparam int unsigned C_SAT = 2;
   localparam int unsigned C_SRC = 3;
   localparam int unsigned C_IE  = 4;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [3:0] ch_idx;
   reg_e       reg_sel;
   logic       in_range;
   logic       access;
   logic       wr_en;

   logic [NUM_CH-1:0][4:0]       ctrl_q, ctrl_d;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]            ch_sel;
   logic [NUM_CH-1:0]            step;

`ifdef APB_CNT_IRQ_EN
   logic [NUM_CH-1:0][CNT_W-1:0] cmp_q, cmp_d;
   logic [NUM_CH-1:0]            match_q, match_d;
   logic                         irq_q, irq_d;
`endif

   // Address bits outside [7:2] are don't-care; this only collects them.
   logic unused_bits;
   assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

   assign ch_idx   = PADDR[7:4];
   assign reg_sel  = reg_e'(PADDR[3:2]);
   assign in_range = ({1'b0, ch_idx} < 5'(NUM_CH));
   assign access   = PSELx & PENABLE;
   assign wr_en    = access & PWRITE & in_range;
   assign PSLVERR  = access & ~in_range;
   assign PREADY   = 1'b1;

   // Per-channel write select and count-step qualifier (uses the old CTRL)
   always_comb begin
      ch_sel = '0;
      step   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_sel[i] = wr_en && (ch_idx == 4'(i));
         step[i]   = ctrl_q[i][C_EN] & (~ctrl_q[i][C_SRC] | CNT_EVT[i]);
      end
   end

   // Next-state for CTRL and counters; a VALUE write overrides the step
   always_comb begin
      ctrl_d = ctrl_q;
      cnt_d  = cnt_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ch_sel[i] && reg_sel == REG_CTRL) begin
            ctrl_d[i] = PWDATA[4:0];
`ifndef APB_CNT_IRQ_EN
            ctrl_d[i][C_IE] = 1'b0;
`endif
         end
         if (ch_sel[i] && reg_sel == REG_VALUE) begin
            cnt_d[i] = PWDATA[CNT_W-1:0];
         end else if (step[i]) begin
            if (ctrl_q[i][C_DIR]) begin
               if (!(ctrl_q[i][C_SAT] && cnt_q[i] == '0)) cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
               if (!(ctrl_q[i][C_SAT] && cnt_q[i] == CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // CTRL and counter registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl_q <= '0;
         cnt_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef APB_CNT_IRQ_EN
   // Compare, sticky match (set beats W1C) and registered IRQ next-state
   always_comb begin
      cmp_d   = cmp_q;
      match_d = match_q;
      irq_d   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ch_sel[i] && reg_sel == REG_COMPARE) cmp_d[i] = PWDATA[CNT_W-1:0];
         match_d[i] = (ctrl_q[i][C_EN] && cnt_q[i] == cmp_q[i]) |
                      (match_q[i] & ~(ch_sel[i] && reg_sel == REG_STATUS && PWDATA[0]));
         irq_d = irq_d | (match_q[i] & ctrl_q[i][C_IE]);
      end
   end

   // Compare, match and IRQ registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cmp_q   <= '0;
         match_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         cmp_q   <= cmp_d;
         match_q <= match_d;
         irq_q   <= irq_d;
      end
   end

   assign IRQ = irq_q;
`else
   assign IRQ = 1'b0;
`endif

   // Read mux: live whenever selected, zero for idle or out-of-range channel
   always_comb begin
      PRDATA = '0;
      if (PSELx && in_range) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 4'(i)) begin
               case (reg_sel)
                  REG_CTRL:    PRDATA = 32'(ctrl_q[i]);
                  REG_VALUE:   PRDATA = 32'(cnt_q[i]);
`ifdef APB_CNT_IRQ_EN
                  REG_COMPARE: PRDATA = 32'(cmp_q[i]);
                  REG_STATUS:  PRDATA = 32'(match_q[i]);
`else
                  REG_COMPARE: PRDATA = '0;
                  REG_STATUS:  PRDATA = '0;
`endif
                  default:     PRDATA = '0;
               endcase
            end
         end
      end
   end

endmodule
